// File: rtl/stream_isolate_responder.sv
// Single-register stream stage that answers an isolate/clear handshake from a
// clearable CDC FIFO's reset controller, draining any open beat before acknowledging.
module stream_isolate_responder #(
    parameter int unsigned WIDTH    = 1,
    parameter type         T        = logic [WIDTH-1:0],
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned CntWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic isolate_i,
    output logic isolate_ack_o,
    input  logic clear_i,
    output logic clear_ack_o,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o,
    output logic drop_o,
    output logic busy_o
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        ISOLATED,
        CLEAR
    } state_t;

    state_t                state_reg;
    logic [CntWidth-1:0]   count_reg;
    logic                  isolate_ack_reg;
    logic                  clear_ack_reg;
    logic                  valid_reg;
    T                      data_reg;

    logic                  in_fire;
    logic                  out_fire;
    logic                  timeout_hit;
    logic                  drop;

    // Upstream is blocked in the same cycle isolate_i rises, so no beat can slip in.
    assign in_ready_o = (state_reg == RUN) & ~isolate_i & (~valid_reg | out_ready_i);
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = valid_reg & out_ready_i;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam logic [CntWidth-1:0] LastCount = CntWidth'(TIMEOUT - 1);
            assign timeout_hit = (count_reg == LastCount);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // A handshake in the expiry cycle wins; an abort (isolate_i low) keeps the beat.
    assign drop = (state_reg == DRAIN) & isolate_i & ~out_fire & timeout_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= RUN;
            count_reg       <= '0;
            isolate_ack_reg <= 1'b0;
            clear_ack_reg   <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (isolate_i) begin
                        if (!valid_reg || out_ready_i) begin
                            state_reg       <= ISOLATED;
                            isolate_ack_reg <= 1'b1;
                        end else begin
                            state_reg <= DRAIN;
                            count_reg <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (!isolate_i) begin
                        state_reg <= RUN;
                    end else if (out_fire || drop) begin
                        state_reg       <= ISOLATED;
                        isolate_ack_reg <= 1'b1;
                    end else if (TIMEOUT > 0) begin
                        count_reg <= count_reg + CntWidth'(1);
                    end
                end
                ISOLATED: begin
                    if (clear_i) begin
                        state_reg     <= CLEAR;
                        clear_ack_reg <= 1'b1;
                    end else if (!isolate_i) begin
                        state_reg       <= RUN;
                        isolate_ack_reg <= 1'b0;
                    end
                end
                CLEAR: begin
                    count_reg <= '0;
                    if (!clear_i) begin
                        state_reg     <= ISOLATED;
                        clear_ack_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= RUN;
                    isolate_ack_reg <= 1'b0;
                    clear_ack_reg   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (state_reg == CLEAR) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_fire) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data_i;
        end else if (out_fire || drop) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid_o   = valid_reg;
    assign out_data_o    = data_reg;
    assign isolate_ack_o = isolate_ack_reg;
    assign clear_ack_o   = clear_ack_reg;
    assign drop_o        = drop;
    assign busy_o        = (state_reg != RUN);

    clear_only_when_isolated: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        clear_i |-> (state_reg == ISOLATED || state_reg == CLEAR));

    isolate_held_during_clear: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_reg == CLEAR && clear_i) |-> isolate_i);

endmodule

// File: tb/tb_stream_isolate_responder.sv
// Drives a plain (no timeout) and a timed (TIMEOUT=4) responder with shared stimulus
// and compares both against a per-cycle behavioural model of the isolate/clear protocol.
module tb_stream_isolate_responder;

    localparam int W       = 8;
    localparam int TO_B    = 4;
    localparam int P_STREAM = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_ISO    = 2;
    localparam int P_CLEAR  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         isolate;
    logic         clear;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic [1:0]   iso_ack;
    logic [1:0]   clr_ack;
    logic [1:0]   drop;
    logic [1:0]   busy;
    logic [W-1:0] out_data [2];

    int n_compared   = 0;
    int n_mismatched = 0;

    int           timeout_of [2] = '{0, TO_B};
    int           m_phase    [2];
    bit           m_full     [2];
    logic [W-1:0] m_data     [2];
    int           m_wait     [2];

    always #5 clk = ~clk;

    stream_isolate_responder #(.WIDTH(W), .TIMEOUT(0)) dut_plain (
        .clk_i(clk), .rst_ni(rst_n),
        .isolate_i(isolate), .isolate_ack_o(iso_ack[0]),
        .clear_i(clear), .clear_ack_o(clr_ack[0]),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .in_data_i(in_data),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_data_o(out_data[0]),
        .drop_o(drop[0]), .busy_o(busy[0])
    );

    stream_isolate_responder #(.WIDTH(W), .TIMEOUT(TO_B)) dut_timed (
        .clk_i(clk), .rst_ni(rst_n),
        .isolate_i(isolate), .isolate_ack_o(iso_ack[1]),
        .clear_i(clear), .clear_ack_o(clr_ack[1]),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .in_data_i(in_data),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_data_o(out_data[1]),
        .drop_o(drop[1]), .busy_o(busy[1])
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_in_ready(input int k);
        return (m_phase[k] == P_STREAM) && !isolate && (!m_full[k] || out_ready);
    endfunction

    // The held beat is discarded in the last allowed drain cycle unless it leaves or isolate aborts.
    function automatic bit m_drop(input int k);
        return (m_phase[k] == P_DRAIN) && isolate && !out_ready &&
               (timeout_of[k] > 0) && (m_wait[k] == timeout_of[k] - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = P_STREAM;
            m_full[k]  = 1'b0;
            m_data[k]  = '0;
            m_wait[k]  = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit accepted  = in_valid && m_in_ready(k);
            bit delivered = m_full[k] && out_ready;
            bit dropped   = m_drop(k);
            if (m_phase[k] == P_CLEAR) begin
                m_full[k] = 1'b0;
                m_data[k] = '0;
            end else if (accepted) begin
                m_full[k] = 1'b1;
                m_data[k] = in_data;
            end else if (delivered || dropped) begin
                m_full[k] = 1'b0;
            end
            case (m_phase[k])
                P_STREAM: if (isolate) begin
                    if (!m_full[k] || delivered) m_phase[k] = P_ISO;
                    else begin
                        m_phase[k] = P_DRAIN;
                        m_wait[k]  = 0;
                    end
                end
                P_DRAIN: begin
                    if (!isolate) m_phase[k] = P_STREAM;
                    else if (delivered || dropped) m_phase[k] = P_ISO;
                    else m_wait[k]++;
                end
                P_ISO: begin
                    if (clear) m_phase[k] = P_CLEAR;
                    else if (!isolate) m_phase[k] = P_STREAM;
                end
                default: begin
                    m_wait[k] = 0;
                    if (!clear) m_phase[k] = P_ISO;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            string p = (k == 0) ? "plain" : "timed";
            check_value({p, ".out_valid"}, out_valid[k], m_full[k]);
            check_value({p, ".out_data"},  out_data[k],  m_data[k]);
            check_value({p, ".in_ready"},  in_ready[k],  m_in_ready(k));
            check_value({p, ".drop"},      drop[k],      m_drop(k));
            check_value({p, ".iso_ack"},   iso_ack[k],   (m_phase[k] == P_ISO) || (m_phase[k] == P_CLEAR));
            check_value({p, ".clr_ack"},   clr_ack[k],   m_phase[k] == P_CLEAR);
            check_value({p, ".busy"},      busy[k],      m_phase[k] != P_STREAM);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_value({tag, ".out_valid"}, out_valid[k], 0);
            check_value({tag, ".out_data"},  out_data[k],  0);
            check_value({tag, ".iso_ack"},   iso_ack[k],   0);
            check_value({tag, ".clr_ack"},   clr_ack[k],   0);
            check_value({tag, ".drop"},      drop[k],      0);
            check_value({tag, ".busy"},      busy[k],      0);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic run_cycle(input bit iso, input bit clr, input bit vin,
                             input logic [W-1:0] din, input bit rdy);
        isolate   = iso;
        clear     = clr;
        in_valid  = vin;
        in_data   = din;
        out_ready = rdy;
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        isolate   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
    endtask

    initial begin
        bit iso_s = 1'b0;
        bit clr_s = 1'b0;
        int stall = 0;
        bit rdy;

        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream of 0x0..0xF
        for (int i = 0; i < 16; i++) run_cycle(0, 0, 1, W'(i), 1);
        run_cycle(0, 0, 0, 0, 1);

        // Isolate with an empty register, then release
        repeat (3) run_cycle(0, 0, 0, 0, 1);
        repeat (3) run_cycle(1, 0, 0, 0, 1);
        run_cycle(0, 0, 0, 0, 1);

        // Hold 0xA under back-pressure while isolating; the timed instance drops it
        run_cycle(0, 0, 1, 8'h0A, 0);
        repeat (5) run_cycle(1, 0, 0, 0, 0);
        repeat (2) run_cycle(1, 0, 0, 0, 1);

        // Four-phase clear, then a beat passes normally
        repeat (3) run_cycle(1, 1, 0, 0, 1);
        repeat (2) run_cycle(1, 0, 0, 0, 1);
        repeat (2) run_cycle(0, 0, 0, 0, 1);
        run_cycle(0, 0, 1, 8'h3C, 1);
        run_cycle(0, 0, 0, 0, 1);

        // Asynchronous reset while draining
        run_cycle(0, 0, 1, 8'h5C, 0);
        run_cycle(1, 0, 0, 0, 0);
        run_cycle(1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_drain");
        model_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(0, 0, 1, 8'h77, 1);
        run_cycle(0, 0, 0, 0, 1);

        // Randomised, protocol-legal traffic
        for (int i = 0; i < 1500; i++) begin
            bit both_iso = (m_phase[0] == P_ISO || m_phase[0] == P_CLEAR) &&
                           (m_phase[1] == P_ISO || m_phase[1] == P_CLEAR);
            if (clr_s) begin
                if ($urandom_range(0, 2) == 0) clr_s = 1'b0;
            end else if (iso_s) begin
                if (both_iso) begin
                    int r = $urandom_range(0, 11);
                    if (r < 3) clr_s = 1'b1;
                    else if (r < 5) iso_s = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    iso_s = 1'b0;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                iso_s = 1'b1;
            end
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else if ($urandom_range(0, 14) == 0) begin
                stall = $urandom_range(2, 7);
                rdy   = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 9) < 7);
            end
            run_cycle(iso_s, clr_s, ($urandom_range(0, 9) < 7), W'($urandom), rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
